instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch front end upstream of the IF/ID pipeline register. Owns the fetch PC and
//  issues one-at-a-time requests to instruction memory over a req/ack handshake.
//  Buffers returned words with their PC in a small FIFO and presents them to decode
//  over a valid/ready handshake. A branch redirect flushes the FIFO and drops any
//  in-flight response.
// PARAMETERS
//  ADDR_W    8     fetch address width; PC wraps modulo 2**ADDR_W
//  INSTR_W   16    instruction word width
//  DEPTH     4     FIFO entries; power of 2, >= 2
//  RESET_PC  8'h00 fetch PC loaded on reset
// PORTS
//  clk            in   1         clock, all state changes on rising edge
//  reset          in   1         synchronous, active-high
//  redirect       in   1         branch taken; load redirect_addr, flush queue
//  redirect_addr  in   ADDR_W    new fetch PC
//  mem_req        out  1         fetch request; held until mem_ack
//  mem_addr       out  ADDR_W    fetch address; stable while mem_req=1
//  mem_ack        in   1         one-cycle pulse; mem_rdata valid this cycle
//  mem_rdata      in   INSTR_W   returned instruction word
//  out_valid      out  1         head entry valid (= count != 0)
//  out_ready      in   1         decode accepts head when out_valid&out_ready
//  out_instr      out  INSTR_W   head instruction
//  out_pc         out  ADDR_W    PC of head instruction
//  occupancy      out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, count=0, rd/wr ptr=0, mem_req=0, mem_addr=RESET_PC,
//   out_valid=0, occupancy=0. Reset mid-request abandons it; a later ack is ignored.
//  All outputs registered or decoded from registered state; no comb path in->out.
//  FSM states (mem_req = state!=IDLE, mem_addr = pc):
//   IDLE:    redirect -> pc=redirect_addr, flush, stay IDLE.
//            else count<DEPTH -> REQ. else stay.
//   REQ:     redirect & mem_ack -> drop data, pc=redirect_addr, flush, -> IDLE.
//            redirect & !mem_ack -> pc=redirect_addr, flush, -> DISCARD.
//            mem_ack -> push {mem_rdata,pc}, pc=pc+1 (wraps);
//             stay REQ if count after push/pop < DEPTH, else -> IDLE.
//            else stay REQ (hold addr).
//   DISCARD: request to pre-redirect addr still open; mem_addr holds OLD addr.
//            Separate reg holds new pc. Redirect here overwrites new pc only.
//            mem_ack -> drop data, -> IDLE, pc=pending addr.
//  Only one request outstanding. Issue requires count<DEPTH, so ack never hits full.
//  Push on ack visible as out_valid next cycle (ack-to-decode latency 1).
//  Pop: out_valid&out_ready&!redirect -> rd_ptr++ , count--.
//  Push and pop same cycle: count unchanged, both pointers advance.
//  Flush (redirect): count=0, rd_ptr=wr_ptr=0 next cycle. Overrides same-cycle
//   push and pop; out_valid=0 next cycle.
//  Pointers wrap modulo DEPTH; pc 8'hFF + 1 -> 8'h00.
//  mem_ack while IDLE: ignored (protocol error, no state change).
// TESTING
//  1 Reset, mem acks 2 cycles after each req, out_ready=1 -> out_pc 00,01,02,03 in
//    order; mem_req first high 1 cycle after reset release.
//  2 out_ready=0, zero-latency acks -> occupancy rises to 4, mem_req drops,
//    mem_addr=04; raise out_ready -> one pop, mem_req returns next cycle.
//  3 Redirect to 8'h40 while REQ pending at 8'h05, ack 3 cycles later with 16'hDEAD ->
//    DEAD never appears on out_instr; next mem_addr=40; queue empty after redirect.
//  4 Redirect same cycle as ack and as pop with count=2 -> ack data dropped,
//    occupancy=0, out_valid=0 next cycle, next request at redirect_addr.
//  5 redirect_addr=8'hFE, fill 4 -> out_pc sequence FE,FF,00,01 (wrap).
//  6 Assert reset while REQ outstanding, ack arrives after release -> ack ignored in
//    IDLE or consumed by the new request at RESET_PC; occupancy 0 until then.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// instr_prefetch_queue : fetch PC owner, one-outstanding imem requester, PC-tagged FIFO to decode
// Revision 1.0
// ============================================================================
module instr_prefetch_queue #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  pc, pc_next;
  logic [ADDR_W-1:0]  pending_pc, pending_next;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_after;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic               push, pop;

  assign pop         = (count != '0) && out_ready && !redirect;
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_pc;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (redirect)
          pc_next = redirect_addr;
        else if (count < CNT_W'(DEPTH))
          state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          if (mem_ack) begin
            pc_next    = redirect_addr;
            state_next = IDLE;
          end else begin
            // pc keeps driving the open request; the new target waits aside
            pending_next = redirect_addr;
            state_next   = DISCARD;
          end
        end else if (mem_ack) begin
          push    = 1'b1;
          pc_next = pc + ADDR_W'(1);
          if (count_after >= CNT_W'(DEPTH))
            state_next = IDLE;
        end
      end
      DISCARD: begin
        if (redirect)
          pending_next = redirect_addr;
        if (mem_ack) begin
          state_next = IDLE;
          pc_next    = redirect ? redirect_addr : pending_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending_pc <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending_pc <= pending_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]    <= pc;
    end
  end

  assign mem_req   = (state != IDLE);
  assign mem_addr  = pc;
  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign occupancy = count;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_instr_prefetch_queue : randomized scoreboard bench for instr_prefetch_queue
// Revision 1.0
// ============================================================================
module tb_instr_prefetch_queue;

  localparam int          ADDR_W   = 8;
  localparam int          INSTR_W  = 16;
  localparam int          DEPTH    = 4;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam int          NCYC     = 4000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_addr = '0;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack = 1'b0;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [2:0]         occupancy;

  instr_prefetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       pushed_now = 1'b0;
  logic       stale = 1'b0;
  logic [7:0] exp_pc = RESET_PC;
  int         idle_run = 0;
  logic       prev_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Stimulus + fetch-stream model: the accepted instruction stream is the run of
  // consecutive PCs starting at the last redirect/reset target.
  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      pushed_now = 1'b0;
      if (prev_reset) begin
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'(RESET_PC));
      end
      if (!mem_req && exp_q.size() < DEPTH) idle_run++;
      else idle_run = 0;
      check("mem_req_stall", 32'(idle_run > 2), 32'd0);

      reset     = (cyc < 2) || ($urandom_range(0, 79) == 0);
      redirect  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_addr = 8'hFE;
        1:       redirect_addr = 8'hFF;
        default: redirect_addr = 8'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      mem_ack   = mem_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      mem_rdata = 16'($urandom);

      if (reset) begin
        exp_pc   = RESET_PC;
        stale    = 1'b0;
        idle_run = 0;
      end else begin
        if (mem_req && mem_ack) begin
          if (!stale && !redirect) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_pc));
            exp_q.push_back('{instr: mem_rdata, pc: exp_pc});
            pushed_now = 1'b1;
            exp_pc     = exp_pc + 8'd1;
          end
          stale = 1'b0;
        end
        if (redirect) begin
          exp_pc   = redirect_addr;
          idle_run = 0;
          if (mem_req && !mem_ack) stale = 1'b1;
        end
      end
      prev_reset = reset;
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: checks DUT state against the scoreboard and consumes handshakes.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else begin
        int exp_occ;
        exp_occ = exp_q.size() - (pushed_now ? 1 : 0);
        check("occupancy", 32'(occupancy), 32'(exp_occ));
        check("out_valid", 32'(out_valid), 32'(exp_occ != 0));
        if (redirect) begin
          exp_q.delete();
        end else if (out_valid && out_ready && exp_occ > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_instr", 32'(out_instr), 32'(e.instr));
          check("out_pc", 32'(out_pc), 32'(e.pc));
        end
      end
    end
  end

endmodule
`default_nettype wire
